// File: rtl/truth_table_sweeper.sv
// Clocked exhaustive sweep of an N_IN-input combinational block: drives each
// input vector in ascending order, samples the block's output into a table and scores it.
module truth_table_sweeper #(
  parameter int                     N_IN     = 2,
  parameter int                     SETTLE   = 1,
  parameter logic [(1<<N_IN)-1:0]   EXPECTED = 4'b0010
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      s_in,
  output logic [N_IN-1:0]           vec,
  output logic                      busy,
  output logic                      done,
  output logic [(1<<N_IN)-1:0]      table_out,
  output logic                      pass,
  output logic [N_IN:0]             mismatch_cnt,
  output logic [N_IN-1:0]           first_fail,
  output logic [1:0]                dbg_state
);

  localparam int T  = 1 << N_IN;
  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int MW = N_IN + 1;
  localparam logic [N_IN-1:0] LAST_VEC = '1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [N_IN-1:0] r_vec;
  logic [CW-1:0]   r_cnt;
  logic [T-1:0]    r_table;
  logic            r_busy;
  logic            r_done;

  logic [T-1:0]    w_diff;
  logic [MW-1:0]   w_popcnt;
  logic [N_IN-1:0] w_first;

  // start is a level sampled on each rising edge; it only has effect in IDLE
  // or DONE, so holding it high never restarts a sweep already in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_vec   <= '0;
      r_cnt   <= '0;
      r_table <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_RUN;
            r_vec   <= '0;
            r_cnt   <= CNT_LOAD;
            r_table <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        S_RUN: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            // Last edge of this vector's window: sample, then advance or finish.
            r_table[r_vec] <= s_in;
            if (r_vec == LAST_VEC) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_vec <= r_vec + N_IN'(1);
              r_cnt <= CNT_LOAD;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Scoring is purely combinational from the registered table; the descending
  // loop leaves the lowest differing index in w_first.
  always_comb begin
    w_diff   = r_table ^ EXPECTED;
    w_popcnt = '0;
    w_first  = '0;
    for (int i = T - 1; i >= 0; i--) begin
      if (w_diff[i]) w_first = N_IN'(i);
    end
    for (int i = 0; i < T; i++) begin
      w_popcnt = w_popcnt + MW'(w_diff[i]);
    end
  end

  assign vec          = r_vec;
  assign busy         = r_busy;
  assign done         = r_done;
  assign table_out    = r_table;
  assign pass         = r_done && (w_diff == '0);
  assign mismatch_cnt = r_done ? w_popcnt : '0;
  assign first_fail   = r_done ? w_first : '0;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: default instance (SETTLE=1) and a SETTLE=0 instance.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  int         mode = 0;

  logic       s_in_a, s_in_b;
  logic [1:0] vec_a, vec_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [3:0] table_a, table_b;
  logic [2:0] mm_a, mm_b;
  logic [1:0] ff_a, ff_b, st_a, st_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Function block models: 0 = f (~x & y), 1 = x | y, 2 = constant 1.
  assign s_in_a = (mode == 0) ? (~vec_a[1] & vec_a[0]) :
                  (mode == 1) ? (vec_a[1] | vec_a[0]) : 1'b1;
  assign s_in_b = ~vec_b[1] & vec_b[0];

  truth_table_sweeper #(.N_IN(2), .SETTLE(1), .EXPECTED(4'b0010)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .s_in(s_in_a),
    .vec(vec_a), .busy(busy_a), .done(done_a), .table_out(table_a),
    .pass(pass_a), .mismatch_cnt(mm_a), .first_fail(ff_a), .dbg_state(st_a)
  );

  truth_table_sweeper #(.N_IN(2), .SETTLE(0), .EXPECTED(4'b0010)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .s_in(s_in_b),
    .vec(vec_b), .busy(busy_b), .done(done_b), .table_out(table_b),
    .pass(pass_b), .mismatch_cnt(mm_b), .first_fail(ff_b), .dbg_state(st_b)
  );

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({busy_a, done_a, vec_a, table_a} !== 8'h00) begin n_bad++;
      $display("FAIL reset_a_regs got %b exp 00000000", {busy_a, done_a, vec_a, table_a}); end
    n_cmp++; if ({pass_a, mm_a, ff_a, st_a} !== 8'h00) begin n_bad++;
      $display("FAIL reset_a_score got %b exp 00000000", {pass_a, mm_a, ff_a, st_a}); end
    n_cmp++; if ({busy_b, done_b, vec_b, table_b, pass_b, mm_b} !== 12'h000) begin n_bad++;
      $display("FAIL reset_b got %b exp 0", {busy_b, done_b, vec_b, table_b, pass_b, mm_b}); end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sweep_f();
    logic [1:0] ev;
    mode = 0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ev = 2'(i / 2);
      n_cmp++; if (vec_a !== ev || busy_a !== 1'b1 || done_a !== 1'b0) begin n_bad++;
        $display("FAIL f_step%0d vec/busy/done got %0d/%b/%b exp %0d/1/0", i, vec_a, busy_a, done_a, ev); end
      @(negedge clk);
    end
    n_cmp++; if (done_a !== 1'b1 || busy_a !== 1'b0 || st_a !== 2'd2) begin n_bad++;
      $display("FAIL f_done done/busy/state got %b/%b/%0d exp 1/0/2", done_a, busy_a, st_a); end
    n_cmp++; if (table_a !== 4'b0010 || vec_a !== 2'd3) begin n_bad++;
      $display("FAIL f_table table/vec got %b/%0d exp 0010/3", table_a, vec_a); end
    n_cmp++; if (pass_a !== 1'b1 || mm_a !== 3'd0 || ff_a !== 2'd0) begin n_bad++;
      $display("FAIL f_score pass/mm/ff got %b/%0d/%0d exp 1/0/0", pass_a, mm_a, ff_a); end
  endtask

  task automatic test_sweep_or();
    mode = 1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n_cmp++; if (done_a !== 1'b0 || table_a !== 4'b0000 || mm_a !== 3'd0 || pass_a !== 1'b0) begin n_bad++;
      $display("FAIL or_restart done/table/mm/pass got %b/%b/%0d/%b exp 0/0000/0/0", done_a, table_a, mm_a, pass_a); end
    repeat (8) @(negedge clk);
    n_cmp++; if (done_a !== 1'b1 || table_a !== 4'b1110) begin n_bad++;
      $display("FAIL or_table done/table got %b/%b exp 1/1110", done_a, table_a); end
    n_cmp++; if (pass_a !== 1'b0 || mm_a !== 3'd2 || ff_a !== 2'd2) begin n_bad++;
      $display("FAIL or_score pass/mm/ff got %b/%0d/%0d exp 0/2/2", pass_a, mm_a, ff_a); end
  endtask

  task automatic test_start_ignored();
    logic [1:0] ev;
    mode = 0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ev = 2'(i / 2);
      start_a = (i == 3);
      n_cmp++; if (vec_a !== ev || done_a !== 1'b0) begin n_bad++;
        $display("FAIL pulse_step%0d vec/done got %0d/%b exp %0d/0", i, vec_a, done_a, ev); end
      @(negedge clk);
    end
    start_a = 1'b0;
    n_cmp++; if (done_a !== 1'b1 || table_a !== 4'b0010) begin n_bad++;
      $display("FAIL pulse_done done/table got %b/%b exp 1/0010", done_a, table_a); end
  endtask

  task automatic test_hold_start();
    logic [1:0] ev;
    mode = 0;
    start_a = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ev = 2'(i / 2);
      n_cmp++; if (vec_a !== ev || done_a !== 1'b0 || busy_a !== 1'b1) begin n_bad++;
        $display("FAIL hold_step%0d vec/done/busy got %0d/%b/%b exp %0d/0/1", i, vec_a, done_a, busy_a, ev); end
      @(negedge clk);
    end
    n_cmp++; if (done_a !== 1'b1 || table_a !== 4'b0010 || pass_a !== 1'b1) begin n_bad++;
      $display("FAIL hold_done done/table/pass got %b/%b/%b exp 1/0010/1", done_a, table_a, pass_a); end
    @(negedge clk);
    start_a = 1'b0;
    n_cmp++; if (done_a !== 1'b0 || busy_a !== 1'b1 || vec_a !== 2'd0 || table_a !== 4'b0000) begin n_bad++;
      $display("FAIL hold_restart done/busy/vec/table got %b/%b/%0d/%b exp 0/1/0/0000", done_a, busy_a, vec_a, table_a); end
    repeat (8) @(negedge clk);
    n_cmp++; if (done_a !== 1'b1 || table_a !== 4'b0010) begin n_bad++;
      $display("FAIL hold_second done/table got %b/%b exp 1/0010", done_a, table_a); end
  endtask

  task automatic test_reset_mid_sweep();
    mode = 2;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (table_a !== 4'b0001 || vec_a !== 2'd1 || busy_a !== 1'b1) begin n_bad++;
      $display("FAIL mid_pre table/vec/busy got %b/%0d/%b exp 0001/1/1", table_a, vec_a, busy_a); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (busy_a !== 1'b0 || vec_a !== 2'd0 || table_a !== 4'b0000 || st_a !== 2'd0) begin n_bad++;
      $display("FAIL mid_async busy/vec/table/state got %b/%0d/%b/%0d exp 0/0/0000/0", busy_a, vec_a, table_a, st_a); end
    @(negedge clk);
    reset = 1'b0;
    mode = 0;
    @(negedge clk);
    n_cmp++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin n_bad++;
      $display("FAIL mid_idle busy/done got %b/%b exp 0/0", busy_a, done_a); end
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (7) @(negedge clk);
    n_cmp++; if (done_a !== 1'b0 || vec_a !== 2'd3) begin n_bad++;
      $display("FAIL mid_edge7 done/vec got %b/%0d exp 0/3", done_a, vec_a); end
    @(negedge clk);
    n_cmp++; if (done_a !== 1'b1 || table_a !== 4'b0010 || pass_a !== 1'b1) begin n_bad++;
      $display("FAIL mid_full done/table/pass got %b/%b/%b exp 1/0010/1", done_a, table_a, pass_a); end
  endtask

  task automatic test_restart_from_done();
    mode = 2;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n_cmp++; if (done_a !== 1'b0 || table_a !== 4'b0000 || ff_a !== 2'd0 || mm_a !== 3'd0) begin n_bad++;
      $display("FAIL ones_restart done/table/ff/mm got %b/%b/%0d/%0d exp 0/0000/0/0", done_a, table_a, ff_a, mm_a); end
    repeat (8) @(negedge clk);
    n_cmp++; if (done_a !== 1'b1 || table_a !== 4'b1111) begin n_bad++;
      $display("FAIL ones_table done/table got %b/%b exp 1/1111", done_a, table_a); end
    n_cmp++; if (pass_a !== 1'b0 || mm_a !== 3'd3 || ff_a !== 2'd0) begin n_bad++;
      $display("FAIL ones_score pass/mm/ff got %b/%0d/%0d exp 0/3/0", pass_a, mm_a, ff_a); end
  endtask

  task automatic test_settle_zero();
    logic [1:0] ev;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ev = 2'(i);
      n_cmp++; if (vec_b !== ev || done_b !== 1'b0 || busy_b !== 1'b1) begin n_bad++;
        $display("FAIL s0_step%0d vec/done/busy got %0d/%b/%b exp %0d/0/1", i, vec_b, done_b, busy_b, ev); end
      @(negedge clk);
    end
    n_cmp++; if (done_b !== 1'b1 || table_b !== 4'b0010 || pass_b !== 1'b1 || mm_b !== 3'd0) begin n_bad++;
      $display("FAIL s0_done done/table/pass/mm got %b/%b/%b/%0d exp 1/0010/1/0", done_b, table_b, pass_b, mm_b); end
  endtask

  initial begin
    test_reset();
    test_sweep_f();
    test_sweep_or();
    test_start_ignored();
    test_hold_start();
    test_reset_mid_sweep();
    test_restart_from_done();
    test_settle_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
